// File: rtl/udp_pkt_arbiter_pkg.sv
// Shared definitions for the two-source UDP packet arbiter: stream widths,
// counter width, default payload limit, FSM state encoding and the length
// legality test.
package udp_pkt_arbiter_pkg;

    localparam int unsigned LEN_W           = 16;
    localparam int unsigned DATA_W          = 512;
    localparam int unsigned KEEP_W          = DATA_W / 8;
    localparam int unsigned CNT_W           = 32;
    localparam int unsigned MAX_LEN_DEFAULT = 1472;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_LEN  = 2'd1,
        SEND_DATA = 2'd2,
        DRAIN     = 2'd3
    } arb_state_t;

    // A payload length is forwardable when it is non-zero and fits the limit.
    function automatic logic len_is_legal(input logic [LEN_W-1:0] len,
                                          input int unsigned      max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/udp_pkt_arbiter_if.sv
// Length + payload stream pair. The master side produces the length and the
// payload beats; the slave side consumes them and returns the readies.
interface udp_pkt_arbiter_if;
    import udp_pkt_arbiter_pkg::*;

    logic [LEN_W-1:0]  len_tdata;
    logic              len_tvalid;
    logic              len_tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output len_tdata, len_tvalid,
        input  len_tready,
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  len_tdata, len_tvalid,
        output len_tready,
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/udp_rr_pick2.sv
// Two-way round-robin pick: the pointer source wins a tie, otherwise the one
// requester present is granted. Purely combinational; the caller owns the
// pointer register.
module udp_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Prefer the pointer source, fall back to the other one.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = ptr;
        if (!req[ptr]) begin
            gnt_idx = ~ptr;
        end
    end

endmodule

// File: rtl/udp_pkt_arbiter.sv
// Arbitrates two length+payload requesters onto one UDP formatter stream.
// A granted packet with a legal length is forwarded (length first, then the
// payload beats until TLAST); an illegal length causes the payload to be
// swallowed instead. Per-source forwarded and global dropped packet counters.
module udp_pkt_arbiter
    import udp_pkt_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    udp_pkt_arbiter_if.slave        s0,
    udp_pkt_arbiter_if.slave        s1,
    udp_pkt_arbiter_if.master       m,
    output logic [CNT_W-1:0]        pkt_count0,
    output logic [CNT_W-1:0]        pkt_count1,
    output logic [CNT_W-1:0]        drop_count
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              ptr_q,   ptr_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [CNT_W-1:0]  pkt0_q,  pkt0_d;
    logic [CNT_W-1:0]  pkt1_q,  pkt1_d;
    logic [CNT_W-1:0]  drop_q,  drop_d;

    // Sources gathered into index-addressable form so the grant can select.
    logic [1:0]        src_len_tvalid;
    logic [LEN_W-1:0]  src_len_tdata [2];
    logic [1:0]        src_tvalid;
    logic [1:0]        src_tlast;
    logic [DATA_W-1:0] src_tdata [2];
    logic [KEEP_W-1:0] src_tkeep [2];
    logic [1:0]        src_len_tready;
    logic [1:0]        src_tready;

    logic              m_len_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;

    logic [1:0]        pick_req;
    logic              gnt_valid;
    logic              gnt_idx;

    assign src_len_tvalid   = {s1.len_tvalid, s0.len_tvalid};
    assign src_len_tdata[0] = s0.len_tdata;
    assign src_len_tdata[1] = s1.len_tdata;
    assign src_tvalid       = {s1.tvalid, s0.tvalid};
    assign src_tlast        = {s1.tlast,  s0.tlast};
    assign src_tdata[0]     = s0.tdata;
    assign src_tdata[1]     = s1.tdata;
    assign src_tkeep[0]     = s0.tkeep;
    assign src_tkeep[1]     = s1.tkeep;

    assign s0.len_tready = src_len_tready[0];
    assign s1.len_tready = src_len_tready[1];
    assign s0.tready     = src_tready[0];
    assign s1.tready     = src_tready[1];

    assign m.len_tdata  = len_q;
    assign m.len_tvalid = m_len_tvalid;
    assign m.tdata      = m_tdata;
    assign m.tkeep      = m_tkeep;
    assign m.tvalid     = m_tvalid;
    assign m.tlast      = m_tlast;

    assign pkt_count0 = pkt0_q;
    assign pkt_count1 = pkt1_q;
    assign drop_count = drop_q;

    // Requests are masked while reset is asserted so no length is consumed
    // (and no LEN_TREADY raised) during a reset that spans several cycles.
    assign pick_req = src_len_tvalid & {2{resetn}};

    udp_rr_pick2 u_pick (
        .req       (pick_req),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state, datapath selection and handshake outputs for the arbiter FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        len_d          = len_q;
        pkt0_d         = pkt0_q;
        pkt1_d         = pkt1_q;
        drop_d         = drop_q;
        src_len_tready = '0;
        src_tready     = '0;
        m_len_tvalid   = 1'b0;
        m_tdata        = '0;
        m_tkeep        = '0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    src_len_tready[gnt_idx] = 1'b1;
                    grant_d = gnt_idx;
                    ptr_d   = ~gnt_idx;
                    len_d   = src_len_tdata[gnt_idx];
                    state_d = len_is_legal(src_len_tdata[gnt_idx], MAX_LEN)
                              ? SEND_LEN : DRAIN;
                end
            end

            SEND_LEN: begin
                m_len_tvalid = 1'b1;
                if (m.len_tready) begin
                    state_d = SEND_DATA;
                end
            end

            SEND_DATA: begin
                m_tdata  = src_tdata[grant_q];
                m_tkeep  = src_tkeep[grant_q];
                m_tvalid = src_tvalid[grant_q];
                m_tlast  = src_tlast[grant_q];
                src_tready[grant_q] = m.tready;
                if (m_tvalid && m.tready && m_tlast) begin
                    if (grant_q) begin
                        pkt1_d = pkt1_q + 32'd1;
                    end else begin
                        pkt0_d = pkt0_q + 32'd1;
                    end
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                src_tready[grant_q] = 1'b1;
                if (src_tvalid[grant_q] && src_tlast[grant_q]) begin
                    drop_d  = drop_q + 32'd1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, pointer, length and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            len_q   <= '0;
            pkt0_q  <= '0;
            pkt1_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            pkt0_q  <= pkt0_d;
            pkt1_q  <= pkt1_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_udp_pkt_arbiter.sv
// Directed bench for udp_pkt_arbiter: inputs change on the falling edge,
// outputs are compared 1 ns later, well away from the rising edge.
module tb_udp_pkt_arbiter;
    import udp_pkt_arbiter_pkg::*;

    logic             clk;
    logic             resetn;
    logic [CNT_W-1:0] pkt_count0;
    logic [CNT_W-1:0] pkt_count1;
    logic [CNT_W-1:0] drop_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    udp_pkt_arbiter_if s0_if ();
    udp_pkt_arbiter_if s1_if ();
    udp_pkt_arbiter_if m_if ();

    udp_pkt_arbiter #(.MAX_LEN(1472)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s0         (s0_if),
        .s1         (s1_if),
        .m          (m_if),
        .pkt_count0 (pkt_count0),
        .pkt_count1 (pkt_count1),
        .drop_count (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [15:0] tag);
        return {32{tag}};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_all();
        s0_if.len_tdata  = '0; s0_if.len_tvalid = 1'b0;
        s0_if.tdata      = '0; s0_if.tkeep      = '0;
        s0_if.tvalid     = 1'b0; s0_if.tlast    = 1'b0;
        s1_if.len_tdata  = '0; s1_if.len_tvalid = 1'b0;
        s1_if.tdata      = '0; s1_if.tkeep      = '0;
        s1_if.tvalid     = 1'b0; s1_if.tlast    = 1'b0;
        m_if.len_tready  = 1'b0;
        m_if.tready      = 1'b0;
    endtask

    initial begin
        int beat;

        // ---------------- reset state (request present during reset) -----
        resetn = 1'b0;
        clear_all();
        s0_if.len_tvalid = 1'b1;
        s0_if.len_tdata  = 16'd64;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_s0_len_tready", s0_if.len_tready, 0);
        check("rst_m_len_tvalid",  m_if.len_tvalid,  0);
        check("rst_m_tvalid",      m_if.tvalid,      0);
        check("rst_m_len_tdata",   m_if.len_tdata,   0);
        check("rst_s0_tready",     s0_if.tready,     0);
        check("rst_pkt_count0",    pkt_count0,       0);
        check("rst_pkt_count1",    pkt_count1,       0);
        check("rst_drop_count",    drop_count,       0);

        // ---------------- S0 only, len 64, one beat -----------------------
        resetn = 1'b1;
        #1;
        check("t1_s0_len_tready",  s0_if.len_tready, 1);
        check("t1_s1_len_tready",  s1_if.len_tready, 0);
        check("t1_idle_len_tvalid", m_if.len_tvalid, 0);
        tick();
        s0_if.len_tvalid = 1'b0;
        #1;
        check("t1_len_tvalid",     m_if.len_tvalid,  1);
        check("t1_len_tdata",      m_if.len_tdata,   64);
        check("t1_sendlen_tvalid", m_if.tvalid,      0);
        check("t1_len_tready_low", s0_if.len_tready, 0);
        m_if.len_tready = 1'b1;
        tick();
        m_if.len_tready = 1'b0;
        s0_if.tvalid = 1'b1;
        s0_if.tdata  = pat(16'h5000);
        s0_if.tkeep  = {KEEP_W{1'b1}};
        s0_if.tlast  = 1'b1;
        m_if.tready  = 1'b1;
        #1;
        check("t1_m_tvalid",       m_if.tvalid,      1);
        check("t1_m_tlast",        m_if.tlast,       1);
        check("t1_m_tdata",        m_if.tdata,       pat(16'h5000));
        check("t1_m_tkeep",        m_if.tkeep,       {KEEP_W{1'b1}});
        check("t1_s0_tready",      s0_if.tready,     1);
        check("t1_s1_tready",      s1_if.tready,     0);
        check("t1_data_len_tvalid", m_if.len_tvalid, 0);
        tick();
        clear_all();
        #1;
        check("t1_pkt_count0",     pkt_count0,       1);
        check("t1_idle_m_tvalid",  m_if.tvalid,      0);

        // ---------------- both valid after reset: S0 then S1 -------------
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        s0_if.len_tvalid = 1'b1; s0_if.len_tdata = 16'd100;
        s1_if.len_tvalid = 1'b1; s1_if.len_tdata = 16'd200;
        #1;
        check("t2_s0_len_tready",  s0_if.len_tready, 1);
        check("t2_s1_len_tready",  s1_if.len_tready, 0);
        tick();
        s0_if.len_tvalid = 1'b0;
        m_if.len_tready  = 1'b1;
        #1;
        check("t2_len0",           m_if.len_tdata,   100);
        check("t2_s1_held_off",    s1_if.len_tready, 0);
        tick();
        m_if.len_tready = 1'b0;
        s0_if.tvalid = 1'b1; s0_if.tdata = pat(16'h5100); s0_if.tlast = 1'b1;
        s1_if.tvalid = 1'b1; s1_if.tdata = pat(16'h1100); s1_if.tlast = 1'b1;
        m_if.tready  = 1'b1;
        #1;
        check("t2_m_tdata_s0",     m_if.tdata,       pat(16'h5100));
        check("t2_s0_tready",      s0_if.tready,     1);
        check("t2_s1_tready",      s1_if.tready,     0);
        tick();
        s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0;
        #1;
        check("t2_s1_len_tready",  s1_if.len_tready, 1);
        check("t2_s0_len_tready2", s0_if.len_tready, 0);
        check("t2_pkt_count0",     pkt_count0,       1);
        check("t2_gap_s1_tready",  s1_if.tready,     0);
        tick();
        s1_if.len_tvalid = 1'b0;
        m_if.len_tready  = 1'b1;
        #1;
        check("t2_len1",           m_if.len_tdata,   200);
        tick();
        m_if.len_tready = 1'b0;
        #1;
        check("t2_m_tdata_s1",     m_if.tdata,       pat(16'h1100));
        check("t2_s1_tready_data", s1_if.tready,     1);
        check("t2_s0_tready_data", s0_if.tready,     0);
        tick();
        clear_all();
        #1;
        check("t2_pkt_count0_end", pkt_count0,       1);
        check("t2_pkt_count1_end", pkt_count1,       1);

        // ---------------- S1 illegal lengths 0 and 1500 are drained ------
        for (int p = 0; p < 2; p++) begin
            s1_if.len_tvalid = 1'b1;
            s1_if.len_tdata  = (p == 0) ? 16'd0 : 16'd1500;
            s1_if.tvalid     = 1'b0;
            s1_if.tlast      = 1'b0;
            m_if.tready      = 1'b1;
            #1;
            check("t3_drop_before",    drop_count,       p);
            check("t3_s1_len_tready",  s1_if.len_tready, 1);
            tick();
            s1_if.len_tvalid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                s1_if.tvalid = 1'b1;
                s1_if.tdata  = pat(16'h1200 + 16'(k));
                s1_if.tlast  = (k == 2);
                #1;
                check("t3_s1_tready",     s1_if.tready,    1);
                check("t3_m_tvalid",      m_if.tvalid,     0);
                check("t3_m_len_tvalid",  m_if.len_tvalid, 0);
                tick();
            end
        end
        clear_all();
        #1;
        check("t3_drop_count",     drop_count,       2);
        check("t3_pkt_count0",     pkt_count0,       1);
        check("t3_pkt_count1",     pkt_count1,       1);

        // ---------------- S0 len 1472 (limit), 4 beats, M_TREADY toggling -
        s0_if.len_tvalid = 1'b1;
        s0_if.len_tdata  = 16'd1472;
        #1;
        check("t4_s0_len_tready",  s0_if.len_tready, 1);
        tick();
        s0_if.len_tvalid = 1'b0;
        s1_if.tvalid = 1'b1; s1_if.tdata = pat(16'h1300); s1_if.tlast = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t4_len_tvalid_hold", m_if.len_tvalid, 1);
            check("t4_len_tdata_hold",  m_if.len_tdata,  1472);
            tick();
        end
        m_if.len_tready = 1'b1;
        #1;
        check("t4_len_tdata_hs",   m_if.len_tdata,   1472);
        tick();
        m_if.len_tready = 1'b0;
        beat = 0;
        for (int c = 0; c < 8; c++) begin
            m_if.tready  = (c % 2 == 1);
            s0_if.tvalid = 1'b1;
            s0_if.tdata  = pat(16'h5400 + 16'(beat));
            s0_if.tlast  = (beat == 3);
            #1;
            check("t4_m_tdata",     m_if.tdata,   pat(16'h5400 + 16'(beat)));
            check("t4_m_tlast",     m_if.tlast,   (beat == 3));
            check("t4_m_tvalid",    m_if.tvalid,  1);
            check("t4_s0_tready",   s0_if.tready, (c % 2 == 1));
            check("t4_s1_no_leak",  s1_if.tready, 0);
            tick();
            if (c % 2 == 1) beat++;
        end
        clear_all();
        #1;
        check("t4_pkt_count0",     pkt_count0,       2);
        check("t4_idle_m_tvalid",  m_if.tvalid,      0);

        // ---------------- reset during beat 2 of 4 ------------------------
        s0_if.len_tvalid = 1'b1;
        s0_if.len_tdata  = 16'd256;
        #1;
        check("t5_s0_len_tready",  s0_if.len_tready, 1);
        tick();
        s0_if.len_tvalid = 1'b0;
        m_if.len_tready  = 1'b1;
        tick();
        m_if.len_tready = 1'b0;
        m_if.tready     = 1'b1;
        s0_if.tvalid = 1'b1; s0_if.tdata = pat(16'h5500); s0_if.tlast = 1'b0;
        #1;
        check("t5_beat1_tvalid",   m_if.tvalid,      1);
        tick();
        s0_if.tdata      = pat(16'h5501);
        s0_if.len_tvalid = 1'b1; s0_if.len_tdata = 16'd64;
        s1_if.len_tvalid = 1'b1; s1_if.len_tdata = 16'd64;
        resetn = 1'b0;
        #1;
        check("t5_beat2_tdata",    m_if.tdata,       pat(16'h5501));
        tick();
        #1;
        check("t5_m_tvalid",       m_if.tvalid,      0);
        check("t5_m_tlast",        m_if.tlast,       0);
        check("t5_m_len_tvalid",   m_if.len_tvalid,  0);
        check("t5_m_len_tdata",    m_if.len_tdata,   0);
        check("t5_s0_tready",      s0_if.tready,     0);
        check("t5_s1_tready",      s1_if.tready,     0);
        check("t5_s0_len_tready",  s0_if.len_tready, 0);
        check("t5_s1_len_tready",  s1_if.len_tready, 0);
        check("t5_pkt_count0",     pkt_count0,       0);
        check("t5_pkt_count1",     pkt_count1,       0);
        check("t5_drop_count",     drop_count,       0);
        resetn = 1'b1;
        s1_if.len_tvalid = 1'b0;
        s0_if.tvalid     = 1'b0;
        #1;
        check("t5_post_s0_grant",  s0_if.len_tready, 1);
        tick();
        s0_if.len_tvalid = 1'b0;
        m_if.len_tready  = 1'b1;
        #1;
        check("t5_post_len",       m_if.len_tdata,   64);
        tick();
        m_if.len_tready = 1'b0;
        s0_if.tvalid = 1'b1; s0_if.tdata = pat(16'h5600); s0_if.tlast = 1'b1;
        #1;
        check("t5_post_tdata",     m_if.tdata,       pat(16'h5600));
        check("t5_post_tlast",     m_if.tlast,       1);
        tick();
        clear_all();
        #1;
        check("t5_post_pkt_count0", pkt_count0,      1);

        // ---------------- PKT_COUNT0 wrap 0xFFFFFFFF -> 0 -----------------
        force dut.pkt0_q = 32'hFFFF_FFFF;
        tick();
        release dut.pkt0_q;
        #1;
        check("t6_preload",        pkt_count0,       32'hFFFF_FFFF);
        s0_if.len_tvalid = 1'b1;
        s0_if.len_tdata  = 16'd64;
        tick();
        s0_if.len_tvalid = 1'b0;
        m_if.len_tready  = 1'b1;
        tick();
        m_if.len_tready = 1'b0;
        m_if.tready     = 1'b1;
        s0_if.tvalid = 1'b1; s0_if.tdata = pat(16'h5700); s0_if.tlast = 1'b1;
        #1;
        check("t6_m_tvalid",       m_if.tvalid,      1);
        tick();
        clear_all();
        #1;
        check("t6_wrap",           pkt_count0,       0);
        check("t6_pkt_count1",     pkt_count1,       0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_pkt_arbiter.md
UDP_PKT_ARBITER -- requirements
Module: udp_pkt_arbiter

Interface
REQ-001 Parameter: MAX_LEN, default 1472, largest legal payload length in bytes.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 resetn  input  1  reset; synchronous, active-low.
REQ-004 S0_LEN_TDATA/S1_LEN_TDATA  input  16  payload byte length per requester.
REQ-005 S0_LEN_TVALID/S1_LEN_TVALID  input  1  length valid.
REQ-006 S0_LEN_TREADY/S1_LEN_TREADY  output  1  length accepted.
REQ-007 S0_TDATA/S1_TDATA  input  512  payload data.
REQ-008 S0_TKEEP/S1_TKEEP  input  64  payload byte enables.
REQ-009 S0_TVALID/S1_TVALID, S0_TLAST/S1_TLAST  input  1  payload valid / last beat.
REQ-010 S0_TREADY/S1_TREADY  output  1  payload ready.
REQ-011 M_LEN_TDATA  output  16, M_LEN_TVALID  output  1, M_LEN_TREADY  input  1: length stream to UDP formatter.
REQ-012 M_TDATA  output  512, M_TKEEP  output  64, M_TVALID  output  1, M_TLAST  output  1, M_TREADY  input  1: payload stream to UDP formatter.
REQ-013 PKT_COUNT0/PKT_COUNT1  output  32  packets forwarded per requester.
REQ-014 DROP_COUNT  output  32  packets discarded for illegal length.

Function
REQ-015 FSM states SHALL be IDLE, SEND_LEN, SEND_DATA, DRAIN.
REQ-016 IDLE: if any Sx_LEN_TVALID, grant per round-robin pointer, assert granted Sx_LEN_TREADY for exactly that one cycle, register length and grant index.
REQ-017 Round-robin: both valid -> pointer source wins; pointer SHALL move to the other source after each grant; pointer = S0 after reset.
REQ-018 Legal length (1..MAX_LEN) SHALL go to SEND_LEN; 0 or >MAX_LEN SHALL go to DRAIN.
REQ-019 SEND_LEN: M_LEN_TVALID=1 with registered length, held stable until M_LEN_TREADY; on handshake -> SEND_DATA.
REQ-020 SEND_DATA: M_TDATA/TKEEP/TVALID/TLAST SHALL be combinational from granted source; granted Sx_TREADY = M_TREADY; non-granted Sx_TREADY=0.
REQ-021 SEND_DATA: on M_TVALID&M_TREADY&M_TLAST, increment PKT_COUNTx, -> IDLE.
REQ-022 DRAIN: granted Sx_TREADY=1, M_TVALID=0; on Sx_TVALID&Sx_TLAST, increment DROP_COUNT, -> IDLE.
REQ-023 M_TVALID and M_LEN_TVALID SHALL be 0 in IDLE; M_TVALID SHALL be 0 in SEND_LEN.
REQ-024 Sx_LEN_TREADY SHALL be 0 outside the IDLE grant cycle; a length SHALL never be consumed while a packet is in flight.
REQ-025 Minimum gap between packets SHALL be one IDLE cycle; length-accept to M_LEN_TVALID latency one cycle.
REQ-026 Counters SHALL be 32-bit and wrap 0xFFFFFFFF -> 0.
REQ-027 Beat count vs. length SHALL NOT be checked; TLAST alone ends a packet.

Reset
REQ-028 Reset SHALL force state IDLE, pointer S0, all counters 0, all TREADY/TVALID outputs 0, M_LEN_TDATA 0.
REQ-029 Reset mid-packet SHALL abandon the packet without asserting M_TLAST; outputs quiescent the cycle after resetn sampled low.

Structure
REQ-030 Shared package/header SHALL hold state encodings and the MAX_LEN default.
REQ-031 Round-robin select SHALL be a sub-module udp_rr_pick2 (two requests, pointer in, grant out).

Verification
REQ-032 S0 only, len 64, 1 beat -> M_LEN=64, one M beat TLAST=1, PKT_COUNT0=1.
REQ-033 S0 and S1 both valid after reset, len 100/200 -> S0 packet first, then S1; counts 1/1.
REQ-034 S1 len 0 then len 1500 (MAX_LEN 1472), 3 beats each -> no M traffic, DROP_COUNT=2, S1_TREADY high all beats.
REQ-035 M_TREADY toggling 50% during 4-beat S0 packet -> M_LEN_TDATA held, beats passed in order, no S1 beat leaks.
REQ-036 resetn low during beat 2 of 4 -> next cycle all VALID/READY 0, counters 0, next packet from S0 handled normally.
REQ-037 PKT_COUNT0 preloaded via force to 0xFFFFFFFF, one packet -> 0.
